seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 138 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 8-digit multiplexed seven-segment scan controller
module seg_scan_ctrl #(
  parameter int DIV   = 1000,
  parameter int BLANK = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       wr_vis,
  input  logic       wr_dp,
  input  logic       clr,
  output logic [7:0] dig_sel,
  output logic [7:0] seg_out,
  output logic       frame
);

  localparam int MAXC = (DIV > BLANK) ? DIV : BLANK;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] BLK_LAST = (BLANK > 0) ? CW'(BLANK - 1) : '0;

  typedef enum logic {SHOW, BLNK} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    idx, idx_nx;
  logic          started, started_nx;

  logic [3:0]    val [8];
  logic [7:0]    vis;
  logic [7:0]    dp;
  logic [6:0]    cur_glyph;

  // a..g segment codes, active-low
  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'h01;
      4'h1: g = 7'h4F;
      4'h2: g = 7'h12;
      4'h3: g = 7'h06;
      4'h4: g = 7'h4C;
      4'h5: g = 7'h24;
      4'h6: g = 7'h20;
      4'h7: g = 7'h0F;
      4'h8: g = 7'h00;
      4'h9: g = 7'h04;
      4'hA: g = 7'h08;
      4'hB: g = 7'h60;
      4'hC: g = 7'h31;
      4'hD: g = 7'h42;
      4'hE: g = 7'h10;
      default: g = 7'h38;
    endcase
    return g;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= SHOW;
      cnt     <= '0;
      idx     <= 3'd0;
      started <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      idx     <= idx_nx;
      started <= started_nx;
    end
  end

  // started marks that idx has wrapped at least once, gating the frame pulse
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt + CW'(1);
    idx_nx     = idx;
    started_nx = started;
    case (state)
      SHOW: begin
        if (cnt == DIV_LAST) begin
          cnt_nx = '0;
          if (BLANK > 0) begin
            state_nx = BLNK;
          end else begin
            idx_nx = idx + 3'd1;
            if (idx == 3'd7) started_nx = 1'b1;
          end
        end
      end
      default: begin
        if (cnt == BLK_LAST) begin
          cnt_nx   = '0;
          state_nx = SHOW;
          idx_nx   = idx + 3'd1;
          if (idx == 3'd7) started_nx = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) val[i] <= 4'h0;
      vis <= 8'h00;
      dp  <= 8'h00;
    end else if (clr) begin
      vis <= 8'h00;
      dp  <= 8'h00;
    end else if (wr_en) begin
      val[wr_addr] <= wr_data;
      vis[wr_addr] <= wr_vis;
      dp[wr_addr]  <= wr_dp;
    end
  end

  assign cur_glyph = glyph(val[idx]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_sel <= 8'hFF;
      seg_out <= 8'hFF;
      frame   <= 1'b0;
    end else begin
      if (state == SHOW && en) begin
        dig_sel <= ~(8'd1 << idx);
        seg_out <= {(vis[idx] ? cur_glyph : 7'h7F), ~(vis[idx] & dp[idx])};
      end else begin
        dig_sel <= 8'hFF;
        seg_out <= 8'hFF;
      end
      frame <= (state == SHOW) && (idx == 3'd0) && (cnt == '0) && started;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed checks of seg_scan_ctrl scan, writes, clr, en and reset
module tb_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst, en, wr_en, wr_vis, wr_dp, clr;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic [7:0] dig_a, seg_a, dig_b, seg_b;
  logic       frame_a, frame_b;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [7:0] exp_glyph [8];

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DIV(4), .BLANK(1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_vis(wr_vis), .wr_dp(wr_dp), .clr(clr),
    .dig_sel(dig_a), .seg_out(seg_a), .frame(frame_a)
  );

  seg_scan_ctrl #(.DIV(1), .BLANK(0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_vis(wr_vis), .wr_dp(wr_dp), .clr(clr),
    .dig_sel(dig_b), .seg_out(seg_b), .frame(frame_b)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // cycle c after reset release shows scan position (c-1); digits are 5 cycles (4 lit + 1 blank) in dut_a
  task automatic scan_check(input int n, input bit en_on);
    int         pos;
    logic [2:0] d;
    logic [7:0] ea, eb;
    for (int k = 0; k < n; k++) begin
      tick();
      pos = (cyc - 1) % 40;
      d   = 3'(pos / 5);
      ea  = (en_on && (pos % 5) != 4) ? ~(8'd1 << d) : 8'hFF;
      eb  = en_on ? ~(8'd1 << ((cyc - 1) % 8)) : 8'hFF;
      chk("dig_a", dig_a, ea);
      chk("seg_a", seg_a, (ea == 8'hFF) ? 8'hFF : exp_glyph[d]);
      chk("frame_a", {7'd0, frame_a}, {7'd0, (pos == 0 && cyc > 1)});
      chk("dig_b", dig_b, eb);
      chk("frame_b", {7'd0, frame_b}, {7'd0, ((cyc - 1) % 8 == 0 && cyc > 1)});
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [3:0] dv, input logic v, input logic p,
                    input logic c);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = dv;
    wr_vis  = v;
    wr_dp   = p;
    clr     = c;
    scan_check(1, 1'b1);
    wr_en   = 1'b0;
    clr     = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 4'h0;
    wr_vis = 1'b0; wr_dp = 1'b0; clr = 1'b0;
    for (int i = 0; i < 8; i++) exp_glyph[i] = 8'hFF;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_dig_a", dig_a, 8'hFF);
    chk("rst_seg_a", seg_a, 8'hFF);
    chk("rst_frame_a", {7'd0, frame_a}, 8'h00);
    chk("rst_dig_b", dig_b, 8'hFF);
    rst = 1'b0;
    cyc = 0;

    scan_check(85, 1'b1);

    wr(3'd0, 4'h5, 1'b1, 1'b0, 1'b0);
    exp_glyph[0] = 8'h49;
    wr(3'd3, 4'hA, 1'b1, 1'b1, 1'b0);
    exp_glyph[3] = 8'h10;
    scan_check(40, 1'b1);

    wr(3'd2, 4'h7, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) exp_glyph[i] = 8'hFF;
    scan_check(40, 1'b1);

    // land the write mid-way through digit 2's lit period
    scan_check(3, 1'b1);
    wr(3'd2, 4'h7, 1'b1, 1'b0, 1'b0);
    exp_glyph[2] = 8'h1F;
    scan_check(37, 1'b1);

    // en low across the frame pulse at cycle 241
    scan_check(28, 1'b1);
    en = 1'b0;
    scan_check(7, 1'b0);
    en = 1'b1;
    scan_check(40, 1'b1);

    scan_check(26, 1'b1);
    chk("pre_rst_dig_b_lit", {7'd0, (dig_b != 8'hFF)}, 8'h01);
    rst = 1'b1;
    #1;
    chk("async_dig_a", dig_a, 8'hFF);
    chk("async_seg_a", seg_a, 8'hFF);
    chk("async_frame_a", {7'd0, frame_a}, 8'h00);
    chk("async_dig_b", dig_b, 8'hFF);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < 8; i++) exp_glyph[i] = 8'hFF;
    scan_check(45, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
